// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M sequencer: funct3 encodings, FSM states,
// the division special-case constants and the signed-overflow predicate.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_START,
    DIV_WAIT,
    DONE
  } stateT;

  // Signed divide/remainder of INT_MIN by -1 cannot be represented.
  function automatic logic isDivOverflow(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    return f3[2] && !f3[0] && (a == INT_MIN) && (b == ALL_ONES);
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational result selection: picks the product half, sign-corrects the
// unsigned divider outputs and substitutes the divide special-case values.
module muldiv_fixup
  import muldiv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [65:0] mulP,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic [31:0] result
);

  // The product's two guard bits only matter to the multiplier itself.
  logic unusedMulTop;
  assign unusedMulTop = ^mulP[65:64];

  always_comb begin
    result = '0;
    if (!funct3[2]) begin
      result = (funct3 == F3_MUL) ? mulP[31:0] : mulP[63:32];
    end else if (opB == '0) begin
      result = funct3[1] ? opA : ALL_ONES;
    end else if (isDivOverflow(funct3, opA, opB)) begin
      result = funct3[1] ? '0 : INT_MIN;
    end else begin
      case (funct3)
        F3_DIV:  result = (opA[31] ^ opB[31]) ? -quotient : quotient;
        F3_DIVU: result = quotient;
        F3_REM:  result = opA[31] ? -remainder : remainder;
        default: result = remainder;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage sequencer for RV32M: latches one instruction, drives the
// multiplier and divider, and stalls the pipeline until the result is ready.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [32:0] mul_a,
  output logic [32:0] mul_b,
  input  logic [65:0] mul_p,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          drain, drainNext;
  logic [2:0]    f3Q;
  logic [31:0]   aQ, bQ;
  logic          accept, signedDiv;
  logic          divStartNext, resultValidNext;
  logic [2:0]    f3Cur;
  logic [31:0]   aCur, bCur, fixResult;

  assign accept = (state == IDLE) && req_valid && !flush;
  assign stall  = accept || (state == MUL_WAIT) || (state == DIV_START) ||
                  (state == DIV_WAIT);

  assign mul_a = {((f3Q == F3_MULH) || (f3Q == F3_MULHSU)) & aQ[31], aQ};
  assign mul_b = {(f3Q == F3_MULH) & bQ[31], bQ};

  assign signedDiv    = f3Q[2] && !f3Q[0];
  assign div_dividend = (signedDiv && aQ[31]) ? -aQ : aQ;
  assign div_divisor  = (signedDiv && bQ[31]) ? -bQ : bQ;

  // Special-case divides finish at the accept edge, before the operand
  // registers are loaded, so the fixup sees the incoming operands then.
  assign f3Cur = accept ? funct3 : f3Q;
  assign aCur  = accept ? op_a : aQ;
  assign bCur  = accept ? op_b : bQ;

  muldiv_fixup fixup (
    .funct3   (f3Cur),
    .opA      (aCur),
    .opB      (bCur),
    .mulP     (mul_p),
    .quotient (div_quotient),
    .remainder(div_remainder),
    .result   (fixResult)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  // A divider still working for a killed instruction must finish (one stale
  // div_done) before a new start pulse may be sent.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    drainNext = drain;
    if (drain && div_done) drainNext = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!funct3[2]) begin
            stateNext = MUL_WAIT;
            cntNext   = CW'(MUL_LAT - 1);
          end else if ((op_b == '0) || isDivOverflow(funct3, op_a, op_b)) begin
            stateNext = DONE;
          end else begin
            stateNext = DIV_START;
          end
        end
      end
      MUL_WAIT: begin
        if (flush)          stateNext = IDLE;
        else if (cnt == '0) stateNext = DONE;
        else                cntNext   = cnt - 1'b1;
      end
      DIV_START: begin
        if (flush) begin
          stateNext = IDLE;
          if (div_start) drainNext = 1'b1;
        end else if (div_start) begin
          stateNext = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        if (flush) begin
          stateNext = IDLE;
          if (!div_done) drainNext = 1'b1;
        end else if (div_done) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    divStartNext    = (stateNext == DIV_START) && !drainNext;
    resultValidNext = (stateNext == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      drain        <= 1'b0;
      f3Q          <= F3_MUL;
      aQ           <= '0;
      bQ           <= '0;
      div_start    <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      cnt          <= cntNext;
      drain        <= drainNext;
      div_start    <= divStartNext;
      result_valid <= resultValidNext;
      if (accept) begin
        f3Q <= funct3;
        aQ  <= op_a;
        bQ  <= op_b;
      end
      if (resultValidNext) result <= fixResult;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with behavioural multiplier and
// divider models and an arithmetic reference for RV32M results.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, result_valid, div_start;
  logic [31:0] result, div_dividend, div_divisor;
  logic [32:0] mul_a, mul_b;
  logic [65:0] mul_p;
  logic [31:0] div_quotient = '0, div_remainder = '0;
  logic        div_done = 1'b0;

  int checks = 0, failures = 0;
  int cyc = 0, startCount = 0, resCount = 0, lastStartCyc = -1;
  int doneCycs[$];
  int divLat = 4;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          expLat;
  } vecT;

  vecT vecs[14];

  always #5 CLK = ~CLK;

  muldiv_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall),
    .result_valid(result_valid), .result(result), .mul_a(mul_a),
    .mul_b(mul_b), .mul_p(mul_p), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done)
  );

  // Multiplier with MUL_LAT-1 register stages after the operands settle.
  always @(posedge CLK) mul_p <= $signed(mul_a) * $signed(mul_b);

  // Iterative divider stand-in with a programmable latency.
  bit          divBusy = 1'b0;
  int          divCnt = 0;
  logic [31:0] qHold, rHold;
  always @(posedge CLK) begin
    if (RST) begin
      divBusy = 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        divBusy = 1'b1;
        divCnt  = divLat;
        qHold   = (div_divisor == 0) ? '1 : div_dividend / div_divisor;
        rHold   = (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      end else if (divBusy) begin
        if (divCnt <= 1) begin
          div_done      <= 1'b1;
          div_quotient  <= qHold;
          div_remainder <= rHold;
          divBusy = 1'b0;
        end else begin
          divCnt--;
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (div_start) begin
      startCount++;
      lastStartCyc = cyc;
    end
    if (div_done) doneCycs.push_back(cyc);
    if (result_valid) resCount++;
    cyc++;
  end

  function automatic logic [31:0] refResult(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb);
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [31:0] res;
  int          lat, accCyc, resCyc, s0, r0, n0, lastDone;
  bit          stallOk, seen;

  // Hold req_valid until the result pulse, as the execute stage would.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge CLK);
    req_valid = 1'b1;
    funct3 = f3;
    op_a = a;
    op_b = b;
    accCyc = cyc;
    lat = 0;
    seen = 1'b0;
    #1 stallOk = stall;
    while (!seen && lat < 300) begin
      @(negedge CLK);
      lat++;
      if (result_valid) begin
        seen = 1'b1;
        stallOk = stallOk && !stall;
      end else begin
        stallOk = stallOk && stall;
      end
    end
    res = result;
    resCyc = cyc;
    req_valid = 1'b0;
    checkOutput("resultValidSeen", 32'(seen), 32'd1);
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input int expLat);
    s0 = startCount;
    applyStimulus(f3, a, b);
    lastDone = (doneCycs.size() > 0) ? doneCycs[doneCycs.size()-1] : -10;
    checkOutput({tag, " result"}, res, exp);
    checkOutput({tag, " stall"}, 32'(stallOk), 32'd1);
    if (expLat >= 0) begin
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " noDivStart"}, 32'(startCount - s0), 32'd0);
    end else begin
      checkOutput({tag, " oneDivStart"}, 32'(startCount - s0), 32'd1);
      checkOutput({tag, " startCycle"}, 32'(lastStartCyc), 32'(accCyc + 1));
      checkOutput({tag, " doneToResult"}, 32'(resCyc), 32'(lastDone + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          rLat;

    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT + 1};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT + 1};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT + 1};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT + 1};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, -1};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, -1};
    vecs[6]  = '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{F3_REM,    32'd5,          32'd0,         32'd5,         1};
    vecs[8]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[9]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[10] = '{F3_DIVU,   32'd100,        32'd7,         32'd14,        -1};
    vecs[11] = '{F3_REMU,   32'd100,        32'd7,         32'd2,         -1};
    vecs[12] = '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, -1};
    vecs[13] = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         -1};

    RST = 1'b1; req_valid = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset resultValid", 32'(result_valid), 32'd0);
    checkOutput("reset divStart", 32'(div_start), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset mulA", mul_a[31:0], 32'd0);
    checkOutput("reset divDividend", div_dividend, 32'd0);

    foreach (vecs[i])
      runAndCheck($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].expLat);

    // Kill a divide in DIV_WAIT; the next divide must wait for the stale done.
    divLat = 6;
    s0 = startCount; r0 = resCount; n0 = doneCycs.size();
    @(negedge CLK);
    req_valid = 1'b1; funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(negedge CLK);
    checkOutput("drain firstDivStart", 32'(div_start), 32'd1);
    @(negedge CLK);
    flush = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    flush = 1'b0;
    #1 checkOutput("drain idleStall", 32'(stall), 32'd0);
    applyStimulus(F3_DIVU, 32'd100, 32'd7);
    checkOutput("drain newResult", res, 32'd14);
    checkOutput("drain startCount", 32'(startCount - s0), 32'd2);
    checkOutput("drain resultCount", 32'(resCount - r0), 32'd1);
    checkOutput("drain doneCount", 32'(doneCycs.size() - n0), 32'd2);
    checkOutput("drain restartAfterStale",
                32'((doneCycs.size() > n0) && (lastStartCyc > doneCycs[n0])), 32'd1);

    // Reset while the multiplier is in flight.
    @(negedge CLK);
    req_valid = 1'b1; funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9;
    @(negedge CLK);
    RST = 1'b1; req_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("midReset stall", 32'(stall), 32'd0);
    checkOutput("midReset resultValid", 32'(result_valid), 32'd0);
    checkOutput("midReset result", result, 32'd0);
    checkOutput("midReset mulA", mul_a[31:0], 32'd0);
    checkOutput("midReset divDivisor", div_divisor, 32'd0);
    runAndCheck("postReset mul", F3_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT + 1);

    for (int k = 0; k < 40; k++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      divLat = $urandom_range(1, 8);
      if (!rf3[2])
        rLat = MUL_LAT + 1;
      else if (rb == 0 || (!rf3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))
        rLat = 1;
      else
        rLat = -1;
      runAndCheck($sformatf("rand%0d f3=%0d", k, rf3), rf3, ra, rb,
                  refResult(rf3, ra, rb), rLat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
